// File: rtl/fwd_scoreboard.sv
// Purpose : operand bypass-select plus long-latency scoreboard; raises stall on load-use or busy-register hazards.
// Latency : fwd_sel/stall/stall_reason are combinational; busy, FSM state, counters and wait_err update on the next clk edge.
// Backpressure: stall holds IF/ID and ID/EX; an issue is accepted only in a cycle with stall=0.
// Ports:
//    clk, rst                      clock, asynchronous active-high reset
//    src_idx/src_valid             ID/EX source register indices and read enables
//    fwd_rd/fwd_ld/fwd_is_load     per bypass stage destination, regfile write enable, data-not-ready flag
//    issue_valid/long/rd           instruction leaving ID/EX
//    cmpl_valid/cmpl_rd            long-latency writeback
//    fwd_sel                       per source: 0 = regfile, k = bypass stage k-1
//    stall/stall_reason            hazard stall and cause (0 none, 1 load-use, 2 scoreboard)
//    stall_cycles/wait_err         saturating stall counter, sticky watchdog error
module fwd_scoreboard #(
   parameter int NUM_SRC  = 2,
   parameter int NUM_FWD  = 2,
   parameter int MAX_WAIT = 64,
   parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SRC*5-1:0]     src_idx,
   input  logic [NUM_SRC-1:0]       src_valid,
   input  logic [NUM_FWD*5-1:0]     fwd_rd,
   input  logic [NUM_FWD-1:0]       fwd_ld,
   input  logic [NUM_FWD-1:0]       fwd_is_load,
   input  logic                     issue_valid,
   input  logic                     issue_long,
   input  logic [4:0]               issue_rd,
   input  logic                     cmpl_valid,
   input  logic [4:0]               cmpl_rd,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     stall,
   output logic [1:0]               stall_reason,
   output logic [31:0]              stall_cycles,
   output logic                     wait_err
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LOAD_USE = 2'd1,
      ST_SB_WAIT  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:1]        r_busy;
   logic [31:0]        w_busy;
   logic [31:0]        w_busy_nxt;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [31:0]        r_stall_cycles;
   logic               r_wait_err;
   logic               w_lu;
   logic               w_sb;
   logic               w_issue_acc;
   logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;

   // x0 is never tracked, so bit 0 of the full view is tied low
   assign w_busy = {r_busy, 1'b0};

   // Bypass select and hazard detection. The stage loop runs oldest to
   // youngest so the youngest matching stage overwrites and wins.
   always_comb begin
      logic [SEL_W-1:0] v_sel;
      logic             v_ld_pend;
      logic [4:0]       v_idx;
      w_fwd_sel = '0;
      w_lu      = 1'b0;
      w_sb      = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         v_sel     = '0;
         v_ld_pend = 1'b0;
         v_idx     = src_idx[5*s +: 5];
         if (src_valid[s] && (v_idx != 5'd0)) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
               if (fwd_ld[k] && (fwd_rd[5*k +: 5] == v_idx)) begin
                  v_sel     = SEL_W'(k + 1);
                  v_ld_pend = fwd_is_load[k];
               end
            end
            // Only the registered busy state counts; an issue being accepted
            // this same cycle is not visible yet.
            if (w_busy[v_idx]) w_sb = 1'b1;
         end
         if (v_ld_pend) w_lu = 1'b1;
         w_fwd_sel[SEL_W*s +: SEL_W] = v_sel;
      end
   end

   assign fwd_sel     = w_fwd_sel;
   assign stall       = w_lu | w_sb;
   assign w_issue_acc = issue_valid & ~stall;

   always_comb begin
      stall_reason = 2'd0;
      if (w_sb)      stall_reason = 2'd2;
      else if (w_lu) stall_reason = 2'd1;
   end

   // Clear first, then set, so a same-index set/clear leaves the bit set.
   always_comb begin
      w_busy_nxt = w_busy;
      if (cmpl_valid)                 w_busy_nxt[cmpl_rd]  = 1'b0;
      if (w_issue_acc && issue_long)  w_busy_nxt[issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt[31:1];
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = ST_RUN;
      if (w_sb)      w_state_nxt = ST_SB_WAIT;
      else if (w_lu) w_state_nxt = ST_LOAD_USE;
   end

   // Watchdog: counts consecutive SB_WAIT cycles, flags once the limit is reached
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_wait_err <= 1'b0;
      end else if (r_state == ST_SB_WAIT) begin
         if (r_wait_cnt != WAIT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
         if (r_wait_cnt >= WAIT_W'(MAX_WAIT - 1)) r_wait_err <= 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      r_stall_cycles <= '0;
      else if (stall && (r_stall_cycles != '1))     r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
   assign wait_err     = r_wait_err;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Purpose : directed self-checking bench for fwd_scoreboard (NUM_SRC=2, NUM_FWD=2, MAX_WAIT=4).
// Latency : combinational outputs checked 1 time unit after inputs change on the falling edge.
// Backpressure: n/a (bench drives all inputs directly).
module tb_fwd_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  src_idx;
   logic [1:0]  src_valid;
   logic [9:0]  fwd_rd;
   logic [1:0]  fwd_ld;
   logic [1:0]  fwd_is_load;
   logic        issue_valid;
   logic        issue_long;
   logic [4:0]  issue_rd;
   logic        cmpl_valid;
   logic [4:0]  cmpl_rd;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic [1:0]  stall_reason;
   logic [31:0] stall_cycles;
   logic        wait_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fwd_scoreboard #(.NUM_SRC(2), .NUM_FWD(2), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .src_idx(src_idx), .src_valid(src_valid),
      .fwd_rd(fwd_rd), .fwd_ld(fwd_ld), .fwd_is_load(fwd_is_load),
      .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
      .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
      .fwd_sel(fwd_sel), .stall(stall), .stall_reason(stall_reason),
      .stall_cycles(stall_cycles), .wait_err(wait_err)
   );

   typedef struct {
      logic [9:0] src_idx;
      logic [1:0] src_valid;
      logic [9:0] fwd_rd;
      logic [1:0] fwd_ld;
      logic [1:0] fwd_is_load;
      logic [3:0] exp_sel;
      logic       exp_stall;
      logic [1:0] exp_reason;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      src_idx = '0; src_valid = '0; fwd_rd = '0; fwd_ld = '0; fwd_is_load = '0;
      issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
      cmpl_valid = 1'b0; cmpl_rd = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // {src1,src0}, valid, {rd1,rd0}, ld, is_load, exp fwd_sel {s1,s0}, stall, reason
      vecs[0] = '{{5'd0, 5'd0},  2'b00, {5'd0, 5'd0},  2'b00, 2'b00, 4'b0000, 1'b0, 2'd0};
      vecs[1] = '{{5'd0, 5'd5},  2'b01, {5'd5, 5'd5},  2'b11, 2'b00, 4'b0001, 1'b0, 2'd0};
      vecs[2] = '{{5'd0, 5'd5},  2'b01, {5'd5, 5'd5},  2'b10, 2'b00, 4'b0010, 1'b0, 2'd0};
      vecs[3] = '{{5'd0, 5'd0},  2'b11, {5'd0, 5'd0},  2'b01, 2'b01, 4'b0000, 1'b0, 2'd0};
      vecs[4] = '{{5'd0, 5'd7},  2'b01, {5'd0, 5'd7},  2'b01, 2'b01, 4'b0001, 1'b1, 2'd1};
      vecs[5] = '{{5'd0, 5'd7},  2'b01, {5'd7, 5'd0},  2'b10, 2'b00, 4'b0010, 1'b0, 2'd0};
      vecs[6] = '{{5'd0, 5'd7},  2'b00, {5'd0, 5'd7},  2'b01, 2'b01, 4'b0000, 1'b0, 2'd0};
      vecs[7] = '{{5'd12, 5'd3}, 2'b11, {5'd12, 5'd3}, 2'b11, 2'b00, 4'b1001, 1'b0, 2'd0};
      vecs[8] = '{{5'd0, 5'd5},  2'b01, {5'd5, 5'd5},  2'b00, 2'b00, 4'b0000, 1'b0, 2'd0};
      vecs[9] = '{{5'd20, 5'd0}, 2'b10, {5'd20, 5'd0}, 2'b10, 2'b10, 4'b1000, 1'b1, 2'd1};

      // Reset state, and forwarding still live while reset is held
      rst = 1'b1;
      idle();
      #2;
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      chk("rst_wait_err", {31'd0, wait_err}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      src_idx = {5'd0, 5'd5}; src_valid = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_ld = 2'b01;
      #1;
      chk("rst_fwd_sel", {28'd0, fwd_sel}, 32'd1);
      @(negedge clk);
      idle();
      rst = 1'b0;

      // Combinational bypass / load-use table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         src_idx = vecs[i].src_idx; src_valid = vecs[i].src_valid;
         fwd_rd = vecs[i].fwd_rd; fwd_ld = vecs[i].fwd_ld; fwd_is_load = vecs[i].fwd_is_load;
         #1;
         chk($sformatf("vec%0d_fwd_sel", i), {28'd0, fwd_sel}, {28'd0, vecs[i].exp_sel});
         chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
         chk($sformatf("vec%0d_reason", i), {30'd0, stall_reason}, {30'd0, vecs[i].exp_reason});
      end

      // Long op to x9; same-cycle read of x9 does not stall, later reads do until completion
      do_reset();
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
      src_idx = {5'd0, 5'd9}; src_valid = 2'b01;
      #1;
      chk("sb_same_cycle_no_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      issue_valid = 1'b0; issue_long = 1'b0;
      #1;
      chk("sb_stall_1", {31'd0, stall}, 32'd1);
      chk("sb_reason_1", {30'd0, stall_reason}, 32'd2);
      @(negedge clk);
      #1;
      chk("sb_stall_2", {31'd0, stall}, 32'd1);
      @(negedge clk);
      cmpl_valid = 1'b1; cmpl_rd = 5'd9;
      #1;
      chk("sb_stall_cmpl_cycle", {31'd0, stall}, 32'd1);
      @(negedge clk);
      cmpl_valid = 1'b0;
      #1;
      chk("sb_stall_after_cmpl", {31'd0, stall}, 32'd0);
      chk("sb_stall_cycles", stall_cycles, 32'd3);
      chk("sb_no_wait_err", {31'd0, wait_err}, 32'd0);

      // Same-index set/clear (set wins), different-index set/clear, reason priority
      do_reset();
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd3;
      cmpl_valid = 1'b1; cmpl_rd = 5'd3;
      @(negedge clk);
      idle();
      src_idx = {5'd7, 5'd3}; src_valid = 2'b11; fwd_rd = {5'd0, 5'd7}; fwd_ld = 2'b01; fwd_is_load = 2'b01;
      #1;
      chk("setclr_busy3_stall", {31'd0, stall}, 32'd1);
      chk("prio_reason_sb", {30'd0, stall_reason}, 32'd2);
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd4;
      cmpl_valid = 1'b1; cmpl_rd = 5'd3;
      @(negedge clk);
      idle();
      src_idx = {5'd0, 5'd3}; src_valid = 2'b01;
      #1;
      chk("diff_clear3", {31'd0, stall}, 32'd0);
      src_idx = {5'd4, 5'd0}; src_valid = 2'b10;
      #1;
      chk("diff_set4", {31'd0, stall}, 32'd1);
      @(negedge clk);
      idle();
      cmpl_valid = 1'b1; cmpl_rd = 5'd17;
      @(negedge clk);
      idle();
      src_idx = {5'd4, 5'd17}; src_valid = 2'b11;
      #1;
      chk("cmpl_nonbusy_no_effect", {31'd0, stall}, 32'd1);
      chk("cmpl_nonbusy_no_err", {31'd0, wait_err}, 32'd0);

      // Watchdog with MAX_WAIT=4, then asynchronous reset in mid-cycle
      do_reset();
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
      @(negedge clk);
      idle();
      src_idx = {5'd0, 5'd9}; src_valid = 2'b01;
      repeat (4) @(negedge clk);
      #1;
      chk("wd_not_yet", {31'd0, wait_err}, 32'd0);
      @(negedge clk);
      #1;
      chk("wd_err_set", {31'd0, wait_err}, 32'd1);
      chk("wd_stall_cycles", stall_cycles, 32'd5);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_stall", {31'd0, stall}, 32'd0);
      chk("arst_wait_err", {31'd0, wait_err}, 32'd0);
      chk("arst_stall_cycles", stall_cycles, 32'd0);
      chk("arst_reason", {30'd0, stall_reason}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_stall", {31'd0, stall}, 32'd0);
      chk("post_rst_wait_err", {31'd0, wait_err}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2: source operand ports checked per cycle.
REQ-002 Parameter NUM_FWD, default 2: bypass stages; index 0 = youngest (EX/MEM), NUM_FWD-1 = oldest (MEM/WB).
REQ-003 Parameter MAX_WAIT, default 64: scoreboard-wait watchdog limit, cycles.
REQ-004 Parameter SEL_W = $clog2(NUM_FWD+1), derived.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-high.
REQ-007 Port src_idx  in  NUM_SRC*5  ID/EX source register indices, port s at [5s+4:5s].
REQ-008 Port src_valid  in  NUM_SRC  source s is actually read.
REQ-009 Port fwd_rd  in  NUM_FWD*5  destination index held in each bypass stage.
REQ-010 Port fwd_ld  in  NUM_FWD  stage writes the regfile (regfile_ld).
REQ-011 Port fwd_is_load  in  NUM_FWD  stage result not yet available (load before data return).
REQ-012 Port issue_valid  in  1  ID/EX instruction advances this cycle.
REQ-013 Port issue_long  in  1  advancing instruction is long-latency (mul/div).
REQ-014 Port issue_rd  in  5  destination of advancing instruction.
REQ-015 Port cmpl_valid  in  1  long-latency unit writes back this cycle.
REQ-016 Port cmpl_rd  in  5  destination of completing long-latency op.
REQ-017 Port fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = regfile, k = bypass stage k-1.
REQ-018 Port stall  out  1  hold IF/ID and ID/EX, insert bubble into EX.
REQ-019 Port stall_reason  out  2  0 none, 1 load-use, 2 scoreboard.
REQ-020 Port stall_cycles  out  32  saturating count of stalled cycles.
REQ-021 Port wait_err  out  1  sticky watchdog error.

Function
REQ-022 fwd_sel combinational: for each valid source with src_idx != 0, select lowest stage k with fwd_ld[k] and fwd_rd[k] == src_idx, value k+1; else 0.
REQ-023 Source index 0 or src_valid=0 SHALL always yield fwd_sel 0 and never cause stall.
REQ-024 Load-use hazard: selected stage k has fwd_is_load[k]=1 -> load-use condition for that source.
REQ-025 busy[31:1] register; busy[0] hardwired 0.
REQ-026 Scoreboard hazard: any valid nonzero source with busy[src_idx]=1, or matching issue_rd while issue_long is being accepted this cycle is not considered (registered only).
REQ-027 stall = load-use OR scoreboard hazard, combinational from current inputs and busy.
REQ-028 stall_reason = 2 if scoreboard hazard, else 1 if load-use, else 0 (scoreboard priority).
REQ-029 Issue accepted only when issue_valid=1 and stall=0; accepted with issue_long=1 and issue_rd!=0 sets busy[issue_rd] at next edge.
REQ-030 cmpl_valid with cmpl_rd!=0 clears busy[cmpl_rd] at next edge; stall drops the cycle after completion.
REQ-031 Same-cycle set and clear of one index: set wins; different indices: both applied.
REQ-032 cmpl_valid for a non-busy index: no effect, no error.
REQ-033 FSM states RUN, LOAD_USE, SB_WAIT, registered; next state = SB_WAIT if scoreboard hazard, LOAD_USE if load-use, else RUN.
REQ-034 wait counter increments each cycle in SB_WAIT, clears on any other state; reaching MAX_WAIT sets wait_err, held until reset.
REQ-035 stall_cycles increments each cycle stall=1; holds at 0xFFFFFFFF.

Reset
REQ-036 rst=1 SHALL asynchronously clear busy, FSM to RUN, wait counter 0, stall_cycles 0, wait_err 0.
REQ-037 During rst, fwd_sel and stall SHALL reflect combinational inputs with busy=0; reset mid-SB_WAIT drops scoreboard stall immediately.

Verification
REQ-038 fwd_ld=2'b11, fwd_rd={x5,x5}, src_idx[0]=x5 -> fwd_sel[0]=1 (youngest wins); stage 0 ld=0 -> fwd_sel[0]=2.
REQ-039 fwd_rd[0]=x0, fwd_ld[0]=1, src x0 -> fwd_sel 0, stall 0.
REQ-040 Stage 0 load to x7, source x7 -> stall=1, stall_reason=1 one cycle; stage advances with is_load=0 at stage 1 -> stall 0, fwd_sel=2.
REQ-041 Issue long to x9, next cycle source x9 -> stall=1 reason 2 until cmpl_rd=x9; stall 0 the cycle after; stall_cycles equals stalled count.
REQ-042 Issue long x3 and cmpl x3 same cycle -> busy[3]=1 afterwards.
REQ-043 MAX_WAIT=4, busy source without completion -> wait_err=1 after 4 SB_WAIT cycles; async rst mid-cycle clears all outputs' state.
